// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2
  } hz_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use detector: a load in EX writes a register the ID instruction reads.
module load_use_detect (
  input  logic [3:0] id_rn,
  input  logic [3:0] id_rm,
  input  logic       id_uses_rn,
  input  logic       id_uses_rm,
  input  logic [3:0] ex_Rd,
  input  logic       ex_mem_read_en,
  input  logic       ex_reg_write_en,
  output logic       hazard
);

  logic rn_hit;
  logic rm_hit;

  always_comb begin
    rn_hit = id_uses_rn && (id_rn == ex_Rd);
    rm_hit = id_uses_rm && (id_rm == ex_Rd);
    hazard = ex_mem_read_en && ex_reg_write_en && (rn_hit || rm_hit);
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: stage enables, IF/ID flush, ID/EX bubble.
// Define HAZARD_PERF_CNT_EN to build the load-use / flush / memory-stall event counters.
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_USE_STALL = 1,
  parameter int unsigned FLUSH_CYCLES   = 1,
  parameter int unsigned MEM_TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  id_rn,
  input  logic [3:0]  id_rm,
  input  logic        id_uses_rn,
  input  logic        id_uses_rm,
  input  logic [3:0]  ex_Rd,
  input  logic        ex_mem_read_en,
  input  logic        ex_reg_write_en,
  input  logic        ex_branch_taken,
  input  logic        mem_busy,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        mem_timeout,
  output logic [31:0] perf_lu_stalls,
  output logic [31:0] perf_flushes,
  output logic [31:0] perf_mem_stalls
);

  localparam int WAIT_W = 16;
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  LU_INIT   = CNT_W'(LOAD_USE_STALL - 1);
  localparam logic [CNT_W-1:0]  FL_INIT   = CNT_W'(FLUSH_CYCLES - 1);

  hz_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic              lu_hazard;
  logic              stall_lu;
  logic              squash;
  logic              run_en;

  load_use_detect u_load_use_detect (
    .id_rn           (id_rn),
    .id_rm           (id_rm),
    .id_uses_rn      (id_uses_rn),
    .id_uses_rm      (id_uses_rm),
    .ex_Rd           (ex_Rd),
    .ex_mem_read_en  (ex_mem_read_en),
    .ex_reg_write_en (ex_reg_write_en),
    .hazard          (lu_hazard)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  // Branch outranks load-use in RUN: the instruction in ID is wrong-path anyway.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_lu = 1'b0;
    squash   = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_branch_taken) begin
          squash = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = FL_INIT;
          end
        end else if (lu_hazard) begin
          stall_lu = 1'b1;
          if (LOAD_USE_STALL > 1) begin
            state_d = LU_STALL;
            cnt_d   = LU_INIT;
          end
        end
      end
      LU_STALL: begin
        stall_lu = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FLUSH: begin
        squash = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
    // A busy data memory freezes everything, including the countdown.
    if (mem_busy) begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      stall_lu = 1'b0;
      squash   = 1'b0;
    end
  end

  always_comb begin
    wait_d    = '0;
    timeout_d = timeout_q;
    if (mem_busy) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
      if (wait_q == WAIT_LAST) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_comb begin
    run_en       = reset_n && !mem_busy;
    pc_en        = run_en && !stall_lu;
    if_id_en     = run_en && !stall_lu;
    id_ex_en     = run_en;
    ex_mem_en    = run_en;
    mem_wb_en    = run_en;
    if_id_flush  = reset_n && squash;
    id_ex_bubble = reset_n && (squash || stall_lu);
    mem_timeout  = timeout_q;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_q, perf_lu_d;
  logic [31:0] perf_fl_q, perf_fl_d;
  logic [31:0] perf_ms_q, perf_ms_d;

  always_comb begin
    perf_lu_d = perf_lu_q;
    perf_fl_d = perf_fl_q;
    perf_ms_d = perf_ms_q;
    if (stall_lu) begin
      perf_lu_d = perf_lu_q + 32'd1;
    end
    if (squash) begin
      perf_fl_d = perf_fl_q + 32'd1;
    end
    if (mem_busy) begin
      perf_ms_d = perf_ms_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_lu_q <= '0;
      perf_fl_q <= '0;
      perf_ms_q <= '0;
    end else begin
      perf_lu_q <= perf_lu_d;
      perf_fl_q <= perf_fl_d;
      perf_ms_q <= perf_ms_d;
    end
  end

  assign perf_lu_stalls  = perf_lu_q;
  assign perf_flushes    = perf_fl_q;
  assign perf_mem_stalls = perf_ms_q;
`else
  assign perf_lu_stalls  = '0;
  assign perf_flushes    = '0;
  assign perf_mem_stalls = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl with LOAD_USE_STALL=2, FLUSH_CYCLES=2, MEM_TIMEOUT=4.
module tb_hazard_stall_ctrl;

  typedef struct packed {
    logic [6:0]  o;
    logic        to;
    logic [31:0] lu;
    logic [31:0] fl;
    logic [31:0] ms;
  } exp_t;

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble}
  localparam logic [6:0] ALL = 7'b11111_00;
  localparam logic [6:0] LU  = 7'b00111_01;
  localparam logic [6:0] FL  = 7'b11111_11;
  localparam logic [6:0] FRZ = 7'b00000_00;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  id_rn = '0, id_rm = '0, ex_Rd = '0;
  logic        id_uses_rn = 1'b0, id_uses_rm = 1'b0;
  logic        ex_mem_read_en = 1'b0, ex_reg_write_en = 1'b0;
  logic        ex_branch_taken = 1'b0, mem_busy = 1'b0;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_bubble, mem_timeout;
  logic [31:0] perf_lu_stalls, perf_flushes, perf_mem_stalls;

  exp_t        sb_q[$];
  exp_t        m_e;
  logic [6:0]  got_o;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] t_lu = 0, t_fl = 0, t_ms = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(
    .LOAD_USE_STALL (2),
    .FLUSH_CYCLES   (2),
    .MEM_TIMEOUT    (4)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .id_rn           (id_rn),
    .id_rm           (id_rm),
    .id_uses_rn      (id_uses_rn),
    .id_uses_rm      (id_uses_rm),
    .ex_Rd           (ex_Rd),
    .ex_mem_read_en  (ex_mem_read_en),
    .ex_reg_write_en (ex_reg_write_en),
    .ex_branch_taken (ex_branch_taken),
    .mem_busy        (mem_busy),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .id_ex_en        (id_ex_en),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_en       (mem_wb_en),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .mem_timeout     (mem_timeout),
    .perf_lu_stalls  (perf_lu_stalls),
    .perf_flushes    (perf_flushes),
    .perf_mem_stalls (perf_mem_stalls)
  );

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      m_e   = sb_q.pop_front();
      got_o = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble};
      checks++;
      if (got_o !== m_e.o) begin
        errors++;
        $display("FAIL outputs t=%0t got=%b want=%b", $time, got_o, m_e.o);
      end
      checks++;
      if (mem_timeout !== m_e.to) begin
        errors++;
        $display("FAIL mem_timeout t=%0t got=%b want=%b", $time, mem_timeout, m_e.to);
      end
      checks++;
      if (perf_lu_stalls !== m_e.lu || perf_flushes !== m_e.fl || perf_mem_stalls !== m_e.ms) begin
        errors++;
        $display("FAIL perf t=%0t got=%0d/%0d/%0d want=%0d/%0d/%0d", $time,
                 perf_lu_stalls, perf_flushes, perf_mem_stalls, m_e.lu, m_e.fl, m_e.ms);
      end
    end
  end

  // mode: 0 idle, 1 rn load-use, 2 rn match but rn unused, 3 rm load-use, 4 rn match, not a load
  task automatic cyc(input logic rstn, input logic busy, input logic br, input int mode,
                     input logic [6:0] eo, input logic eto);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n         = rstn;
    mem_busy        = busy;
    ex_branch_taken = br;
    id_rn = 4'd0; id_rm = 4'd0; ex_Rd = 4'd0;
    id_uses_rn = 1'b0; id_uses_rm = 1'b0;
    ex_mem_read_en = 1'b0; ex_reg_write_en = 1'b0;
    case (mode)
      1: begin id_rn = 4'd3; id_uses_rn = 1'b1; id_rm = 4'd5; id_uses_rm = 1'b1;
               ex_Rd = 4'd3; ex_mem_read_en = 1'b1; ex_reg_write_en = 1'b1; end
      2: begin id_rn = 4'd3; id_uses_rn = 1'b0; id_rm = 4'd5; id_uses_rm = 1'b1;
               ex_Rd = 4'd3; ex_mem_read_en = 1'b1; ex_reg_write_en = 1'b1; end
      3: begin id_rn = 4'd2; id_uses_rn = 1'b1; id_rm = 4'd7; id_uses_rm = 1'b1;
               ex_Rd = 4'd7; ex_mem_read_en = 1'b1; ex_reg_write_en = 1'b1; end
      4: begin id_rn = 4'd3; id_uses_rn = 1'b1;
               ex_Rd = 4'd3; ex_mem_read_en = 1'b0; ex_reg_write_en = 1'b1; end
      default: ;
    endcase
    if (!rstn) begin
      t_lu = 0; t_fl = 0; t_ms = 0;
    end
`ifdef HAZARD_PERF_CNT_EN
    e = '{o: eo, to: eto, lu: t_lu, fl: t_fl, ms: t_ms};
`else
    e = '{o: eo, to: eto, lu: 32'd0, fl: 32'd0, ms: 32'd0};
`endif
    sb_q.push_back(e);
    if (rstn) begin
      if (busy) t_ms++;
      if (eo[1]) t_fl++;
      if (eo[0] && !eo[1]) t_lu++;
    end
  endtask

  initial begin
    // Reset state
    cyc(0, 0, 0, 0, FRZ, 0);
    cyc(0, 0, 0, 1, FRZ, 0);
    cyc(1, 0, 0, 0, ALL, 0);
    // Load-use on rn: two stall cycles, hazard in LU_STALL ignored
    cyc(1, 0, 0, 1, LU,  0);
    cyc(1, 0, 0, 1, LU,  0);
    cyc(1, 0, 0, 0, ALL, 0);
    // Near misses
    cyc(1, 0, 0, 2, ALL, 0);
    cyc(1, 0, 0, 4, ALL, 0);
    // Load-use on rm
    cyc(1, 0, 0, 3, LU,  0);
    cyc(1, 0, 0, 0, LU,  0);
    cyc(1, 0, 0, 0, ALL, 0);
    // Branch with simultaneous load-use; branch in FLUSH ignored
    cyc(1, 0, 1, 1, FL,  0);
    cyc(1, 0, 1, 1, FL,  0);
    cyc(1, 0, 0, 0, ALL, 0);
    // mem_busy for 5 cycles inside LU_STALL; timeout (4) trips on the way
    cyc(1, 0, 0, 1, LU,  0);
    cyc(1, 1, 0, 1, FRZ, 0);
    cyc(1, 1, 0, 1, FRZ, 0);
    cyc(1, 1, 0, 1, FRZ, 0);
    cyc(1, 1, 0, 1, FRZ, 0);
    cyc(1, 1, 0, 1, FRZ, 1);
    cyc(1, 0, 0, 0, LU,  1);
    cyc(1, 0, 0, 0, ALL, 1);
    // Busy outranks branch: no flush latched
    cyc(1, 1, 1, 1, FRZ, 1);
    cyc(1, 0, 0, 0, ALL, 1);
    // Reset mid-FLUSH
    cyc(1, 0, 1, 0, FL,  1);
    cyc(0, 0, 0, 0, FRZ, 0);
    cyc(0, 0, 1, 1, FRZ, 0);
    cyc(1, 0, 0, 0, ALL, 0);
    // Timeout: 6 busy cycles, flag sticky afterwards
    cyc(1, 1, 0, 0, FRZ, 0);
    cyc(1, 1, 0, 0, FRZ, 0);
    cyc(1, 1, 0, 0, FRZ, 0);
    cyc(1, 1, 0, 0, FRZ, 0);
    cyc(1, 1, 0, 0, FRZ, 1);
    cyc(1, 1, 0, 0, FRZ, 1);
    cyc(1, 0, 0, 0, ALL, 1);
    cyc(1, 0, 0, 1, LU,  1);
    cyc(1, 0, 0, 0, LU,  1);
    cyc(1, 0, 0, 0, ALL, 1);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
